pong_match_fsm: RTL and testbench

Parametrised match controller for the Pong game: owns game state, per-player scores, serve delay and match countdown for 2–4 players, in timed, first-to-N or combined mode. Sits between the ball/paddle engine (which reports misses and obeys `stop`/`serve_req`) and the display path (score matrices, seven-segment timer, VGA). Adds rising-edge detection on `start`/`pause`, pause/resume, score saturation, win detection and tie reporting.

---
 rtl/pong_match_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_pong_match_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_fsm.sv
// Pong match controller: game state, per-player scores, serve delay and countdown.
// Ends the match on time-out or first-to-WIN_SCORE and reports the winner or a tie.
module pong_match_fsm #(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned SCORE_W       = 3,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned MATCH_SECONDS = 180,
  parameter int unsigned TIME_W        = 8,
  parameter int unsigned SERVE_DELAY   = 100_000_000,
  parameter bit          AUTO_SERVE    = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           tick_1hz,
  input  logic [1:0]                     mode,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [2:0]                     state,
  output logic                           stop,
  output logic                           serve_req,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [TIME_W-1:0]              time_left,
  output logic [1:0]                     winner,
  output logic                           winner_valid,
  output logic                           tie
);

  localparam int unsigned CntW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CntW-1:0]    CntLast  = CntW'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WinVal   = SCORE_W'(WIN_SCORE);
  localparam logic [TIME_W-1:0]  TimeLoad = TIME_W'(MATCH_SECONDS);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StServeWait = 3'd1,
    StPlay      = 3'd2,
    StPaused    = 3'd3,
    StOver      = 3'd4
  } state_t;

  state_t                         state_q, state_d, origin_q, origin_d;
  logic                           start_q, pause_q;
  logic [1:0]                     mode_q, mode_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d, scores_hit;
  logic [TIME_W-1:0]              time_q, time_d, time_dec;
  logic                           serve_req_q, serve_req_d;
  logic                           stop_q, stop_d;
  logic [1:0]                     winner_q, winner_d;
  logic                           winner_valid_q, winner_valid_d;
  logic                           tie_q, tie_d;

  logic                           start_edge, pause_edge;
  logic                           timed_mode, target_mode;
  logic                           any_miss, win_hit, timeout;
  logic [SCORE_W-1:0]             best_val, cur_val;
  logic [1:0]                     best_idx;
  logic                           best_tie;

  assign start_edge  = start & ~start_q;
  assign pause_edge  = pause & ~pause_q;
  assign timed_mode  = (mode_q != 2'd1);
  assign target_mode = (mode_q != 2'd0);
  assign any_miss    = |miss;
  assign time_dec    = (time_q != '0) ? time_q - TIME_W'(1) : time_q;
  // A tick that takes the clock from 1 to 0 ends a timed match.
  assign timeout     = tick_1hz && timed_mode && (time_q == TIME_W'(1));

  // Scores as they would stand if this cycle's miss pattern were honoured.
  always_comb begin
    scores_hit = scores_q;
    win_hit    = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!miss[i] && scores_q[i*SCORE_W +: SCORE_W] != ScoreMax) begin
        scores_hit[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
      end
      if (scores_hit[i*SCORE_W +: SCORE_W] >= WinVal) begin
        win_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    scores_d    = scores_q;
    time_d      = time_q;
    serve_req_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        scores_d = '0;
        time_d   = TimeLoad;
        if (start_edge) begin
          mode_d  = (mode == 2'd3) ? 2'd2 : mode;
          cnt_d   = '0;
          state_d = StServeWait;
        end
      end
      StServeWait: begin
        if (tick_1hz) time_d = time_dec;
        if (timeout) begin
          state_d = StOver;
        end else if (pause_edge) begin
          origin_d = StServeWait;
          state_d  = StPaused;
        end else if (cnt_q == CntLast) begin
          if (AUTO_SERVE || start_edge) begin
            state_d     = StPlay;
            serve_req_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPlay: begin
        if (tick_1hz) time_d = time_dec;
        if (any_miss) begin
          scores_d = scores_hit;
          cnt_d    = '0;
          state_d  = (target_mode && win_hit) ? StOver : StServeWait;
        end
        if (timeout) begin
          state_d = StOver;
        end else if (!any_miss && pause_edge) begin
          origin_d = StPlay;
          state_d  = StPaused;
        end
      end
      StPaused: begin
        if (pause_edge) state_d = origin_q;
      end
      StOver: begin
        if (start_edge) begin
          scores_d = '0;
          time_d   = TimeLoad;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stop_d = (state_d != StPlay);

  // Result is taken from the final scores on the cycle that enters OVER.
  always_comb begin
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    tie_d          = tie_q;
    best_val       = scores_d[SCORE_W-1:0];
    best_idx       = 2'd0;
    best_tie       = 1'b0;
    cur_val        = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      cur_val = scores_d[i*SCORE_W +: SCORE_W];
      if (cur_val > best_val) begin
        best_val = cur_val;
        best_idx = 2'(i);
        best_tie = 1'b0;
      end else if (cur_val == best_val) begin
        best_tie = 1'b1;
      end
    end
    if (state_d == StOver && state_q != StOver) begin
      winner_d       = best_idx;
      winner_valid_d = ~best_tie;
      tie_d          = best_tie;
    end else if (state_d == StIdle) begin
      winner_d       = 2'd0;
      winner_valid_d = 1'b0;
      tie_d          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      origin_q       <= StServeWait;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
      mode_q         <= 2'd0;
      cnt_q          <= '0;
      scores_q       <= '0;
      time_q         <= TimeLoad;
      serve_req_q    <= 1'b0;
      stop_q         <= 1'b1;
      winner_q       <= 2'd0;
      winner_valid_q <= 1'b0;
      tie_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      origin_q       <= origin_d;
      start_q        <= start;
      pause_q        <= pause;
      mode_q         <= mode_d;
      cnt_q          <= cnt_d;
      scores_q       <= scores_d;
      time_q         <= time_d;
      serve_req_q    <= serve_req_d;
      stop_q         <= stop_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      tie_q          <= tie_d;
    end
  end

  assign state        = state_q;
  assign stop         = stop_q;
  assign serve_req    = serve_req_q;
  assign scores       = scores_q;
  assign time_left    = time_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_pong_match_fsm.sv
// Directed bench: 2-player auto-serve, 4-player saturation and a manual-serve instance
// sharing one set of control inputs.
module tb_pong_match_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] miss2 = '0, miss0 = '0;
  logic [3:0] miss4 = '0;

  logic [2:0] st2, st4, st0;
  logic       stop2, stop4, stop0, sreq2, sreq4, sreq0;
  logic [5:0] sc2, sc0;
  logic [7:0] sc4;
  logic [7:0] tl2, tl4, tl0;
  logic [1:0] win2, win4, win0;
  logic       wv2, wv4, wv0, tie2, tie4, tie0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pong_match_fsm #(
    .NUM_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(3), .MATCH_SECONDS(3), .TIME_W(8),
    .SERVE_DELAY(4), .AUTO_SERVE(1'b1)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .tick_1hz(tick), .mode(mode),
    .miss(miss2), .state(st2), .stop(stop2), .serve_req(sreq2), .scores(sc2),
    .time_left(tl2), .winner(win2), .winner_valid(wv2), .tie(tie2)
  );

  pong_match_fsm #(
    .NUM_PLAYERS(4), .SCORE_W(2), .WIN_SCORE(3), .MATCH_SECONDS(180), .TIME_W(8),
    .SERVE_DELAY(4), .AUTO_SERVE(1'b1)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .tick_1hz(tick), .mode(mode),
    .miss(miss4), .state(st4), .stop(stop4), .serve_req(sreq4), .scores(sc4),
    .time_left(tl4), .winner(win4), .winner_valid(wv4), .tie(tie4)
  );

  pong_match_fsm #(
    .NUM_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(5), .MATCH_SECONDS(180), .TIME_W(8),
    .SERVE_DELAY(4), .AUTO_SERVE(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .tick_1hz(tick), .mode(mode),
    .miss(miss0), .state(st0), .stop(stop0), .serve_req(sreq0), .scores(sc0),
    .time_left(tl0), .winner(win0), .winner_valid(wv0), .tie(tie0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step();
    // Reset state
    check("rst_state", st2, 0);
    check("rst_stop", stop2, 1);
    check("rst_sreq", sreq2, 0);
    check("rst_scores", sc2, 0);
    check("rst_time", tl2, 3);
    check("rst_winner", {win2, wv2, tie2}, 0);

    // 1: start edge, 4 cycles of SERVE_WAIT, then PLAY with one-cycle serve_req
    mode = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_sw", st2, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_sw_hold", st2, 1);
    end
    step();
    check("t1_play", st2, 2);
    check("t1_sreq", sreq2, 1);
    check("t1_stop", stop2, 0);
    step();
    check("t1_sreq_drop", sreq2, 0);

    // 2: held miss counts once; all-miss leaves scores alone
    miss2 = 2'b01;
    step(3);
    miss2 = 2'b00;
    check("t2_scores", sc2, 6'o10);
    check("t2_sw", st2, 1);
    step(2);
    check("t2_play", st2, 2);
    miss2 = 2'b11;
    step();
    miss2 = 2'b00;
    check("t2_allmiss", sc2, 6'o10);
    check("t2_allmiss_sw", st2, 1);

    // 3: first-to-3, p1 reaches 3
    step(4);
    miss2 = 2'b01;
    step();
    miss2 = 2'b00;
    check("t3_p1_2", sc2, 6'o20);
    check("t3_not_over", st2, 1);
    step(4);
    check("t3_play", st2, 2);
    miss2 = 2'b01;
    step();
    miss2 = 2'b00;
    check("t3_over", st2, 4);
    check("t3_scores", sc2, 6'o30);
    check("t3_result", {win2, wv2, tie2}, 4'b0110);
    check("t3_stop", stop2, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_idle", st2, 0);
    check("t3_idle_scores", sc2, 0);
    check("t3_idle_res", {win2, wv2, tie2}, 0);

    // 4: timed match, third tick coincides with a miss by p1
    mode = 2'd0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step(4);
    check("t4_play", st2, 2);
    miss2 = 2'b01;
    step();
    miss2 = 2'b00;
    step(4);
    tick = 1'b1; step(); tick = 1'b0;
    check("t4_time2", tl2, 2);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check("t4_time1", tl2, 1);
    check("t4_still_play", st2, 2);
    step();
    tick = 1'b1; miss2 = 2'b10;
    step();
    tick = 1'b0; miss2 = 2'b00;
    check("t4_over", st2, 4);
    check("t4_time0", tl2, 0);
    check("t4_scores", sc2, 6'o11);
    check("t4_tie", {win2, wv2, tie2}, 4'b0001);

    // 5: pause in SERVE_WAIT freezes counter and clock
    start = 1'b1; step(); start = 1'b0;
    check("t5_idle", st2, 0);
    step();
    start = 1'b1; step(); start = 1'b0;
    step(2);
    pause = 1'b1; step(); pause = 1'b0;
    check("t5_paused", st2, 3);
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    check("t5_paused_hold", st2, 3);
    check("t5_time_frozen", tl2, 3);
    pause = 1'b1; step(); pause = 1'b0;
    check("t5_resume", st2, 1);
    step();
    check("t5_sw", st2, 1);
    step();
    check("t5_play", st2, 2);
    check("t5_sreq", sreq2, 1);

    // 6: 4 players saturate; manual serve waits for start; async reset mid-PLAY
    rst = 1'b1; step(); rst = 1'b0; step();
    mode = 2'd0; start = 1'b1; step(); start = 1'b0;
    step(4);
    check("t6_play4", st4, 2);
    check("t6_manual_wait", st0, 1);
    start = 1'b1; step(); start = 1'b0;
    check("t6_manual_play", st0, 2);
    check("t6_manual_sreq", sreq0, 1);
    check("t6_play4_hold", st4, 2);
    for (int i = 0; i < 4; i++) begin
      miss4 = 4'b0001; step(); miss4 = 4'b0000;
      if (i == 0) check("t6_first", sc4, 8'h54);
      step(4);
    end
    check("t6_sat", sc4, 8'hFC);
    check("t6_play_again", st4, 2);
    check("t6_sreq4", sreq4, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_state", st4, 0);
    check("t6_rst_stop", stop4, 1);
    check("t6_rst_sreq", sreq4, 0);
    check("t6_rst_scores", sc4, 0);
    check("t6_rst_time", tl4, 180);
    check("t6_rst_state0", st0, 0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
